// File: rtl/keypad_event_queue.sv
// keypad_event_queue: turns debounced key levels into a queue of key-press
// events. Rising edges are collected in a pending mask and pushed one per
// cycle, lowest key index first, into a show-ahead FIFO of DEPTH entries.
// A sticky overflow flag records presses that were lost because the key
// pressed again while its earlier press was still waiting.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN adds typematic auto-repeat
// events for the most recently pressed key that is still held.
module keypad_event_queue #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 1250000,
  parameter int REPEAT_PERIOD = 250000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [15:0]              keyboard,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [3:0]               event_code,
  output logic                     event_repeat,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     overflow,
  input  logic                     overflow_clear
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  logic [15:0]     prevKeys_q;
  logic [15:0]     pending_q, pending_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [3:0]      codeMem_q [DEPTH];

  logic [15:0]     rise;
  logic [15:0]     candidate;
  logic [3:0]      pickIdx;
  logic [15:0]     pushMask;
  logic            pop;
  logic            pushPermitted;
  logic            pressPush;
  logic            repeatPush;
  logic            push;
  logic [3:0]      pushCode;
  logic            overflowSet;

  assign rise        = keyboard & ~prevKeys_q;
  assign candidate   = pending_q | rise;
  assign event_valid = (count_q != '0);
  assign event_count = count_q;
  assign overflow    = overflow_q;
  assign pop         = event_valid & event_ready;

  // A slot is available if the FIFO is not full, or if the head leaves this cycle.
  assign pushPermitted = (count_q < CntW'(DEPTH)) | ((count_q == CntW'(DEPTH)) & pop);
  assign pressPush     = (|candidate) & pushPermitted;
  assign push          = pressPush | repeatPush;
  assign pushMask      = pressPush ? (16'h0001 << pickIdx) : 16'h0000;

  // Lowest-index candidate wins, so scan from the top and let lower bits overwrite.
  always_comb begin
    pickIdx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (candidate[i]) pickIdx = 4'(i);
    end
  end

  // Pending keeps every candidate not pushed; a press that arrives again while still pending is lost.
  always_comb begin
    pending_d   = candidate & ~pushMask;
    overflowSet = |(rise & pending_q & ~pushMask);
    overflow_d  = overflow_q;
    if (overflowSet) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (pop) rdPtr_d = rdPtr_q + PtrW'(1);
    if (push) wrPtr_d = wrPtr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously so reset drops every queued and pending event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prevKeys_q <= '0;
      pending_q  <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prevKeys_q <= keyboard;
      pending_q  <= pending_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO payload storage; contents are only visible while occupancy is non-zero.
  always_ff @(posedge clock) begin
    if (push) codeMem_q[wrPtr_q] <= pushCode;
  end

  assign event_code = event_valid ? codeMem_q[rdPtr_q] : 4'd0;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int TimerMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TimerW   = $clog2(TimerMax + 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        track_q, track_d;
  logic              active_q, active_d;
  logic              repMem_q [DEPTH];
  logic              trackHeld;
  logic              timerZero;

  assign trackHeld  = keyboard[track_q];
  assign timerZero  = (timer_q == '0);
  assign repeatPush = active_q & trackHeld & timerZero & pushPermitted & ~pressPush;
  assign pushCode   = pressPush ? pickIdx : track_q;

  // Repeat tracking: restart on every press push, stop on release, reload the timer each time it expires.
  always_comb begin
    timer_d  = timer_q;
    track_d  = track_q;
    active_d = active_q;
    if (pressPush) begin
      active_d = 1'b1;
      track_d  = pickIdx;
      timer_d  = TimerW'(REPEAT_DELAY - 1);
    end else if (active_q & ~trackHeld) begin
      active_d = 1'b0;
    end else if (active_q) begin
      if (timerZero) begin
        timer_d = TimerW'(REPEAT_PERIOD - 1);
      end else begin
        timer_d = timer_q - TimerW'(1);
      end
    end
  end

  // Repeat tracker state, idle after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      track_q  <= '0;
      active_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      track_q  <= track_d;
      active_q <= active_d;
    end
  end

  // Repeat flag travels alongside each stored key code.
  always_ff @(posedge clock) begin
    if (push) repMem_q[wrPtr_q] <= repeatPush;
  end

  assign event_repeat = event_valid ? repMem_q[rdPtr_q] : 1'b0;
`else
  // Auto-repeat is compiled out; the timing parameters only fold into a constant zero.
  localparam bit RepeatCfg = (REPEAT_DELAY > 0) || (REPEAT_PERIOD > 0);

  assign repeatPush   = 1'b0;
  assign pushCode     = pickIdx;
  assign event_repeat = RepeatCfg & 1'b0;
`endif

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed testbench for keypad_event_queue: a table of single-cycle vectors
// for press ordering, FIFO fill/drain and overflow, plus hand-written
// sequences for full-with-pop, asynchronous reset and auto-repeat timing.
module tb_keypad_event_queue;

  logic        clock;
  logic        reset_n;
  logic [15:0] keyboard;
  logic        event_valid;
  logic        event_ready;
  logic [3:0]  event_code;
  logic        event_repeat;
  logic [2:0]  event_count;
  logic        overflow;
  logic        overflow_clear;

  int vectorCount = 0;
  int missCount   = 0;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  typedef struct {
    logic [15:0] kb;
    logic        rdy;
    logic        clr;
    logic        expValid;
    logic [3:0]  expCode;
    logic [2:0]  expCount;
    logic        expOv;
  } vec_t;

  vec_t vecs [29];

  keypad_event_queue #(
    .DEPTH(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .keyboard(keyboard),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_code(event_code),
    .event_repeat(event_repeat),
    .event_count(event_count),
    .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, let one rising edge pass, then settle before sampling.
  task automatic applyStimulus(input logic [15:0] kb, input logic rdy, input logic clr);
    keyboard       = kb;
    event_ready    = rdy;
    overflow_clear = clr;
    @(posedge clock);
    #1;
  endtask

  // Compare every output against the expected values and tally the result.
  task automatic checkOutput(input string name, input logic expValid, input logic [3:0] expCode,
                             input logic expRep, input logic [2:0] expCount, input logic expOv);
    vectorCount++;
    if (event_valid !== expValid || event_code !== expCode || event_repeat !== expRep ||
        event_count !== expCount || overflow !== expOv) begin
      missCount++;
      $display("[TB] FAIL %s: got valid=%0b code=%0d rep=%0b count=%0d ovf=%0b, expected valid=%0b code=%0d rep=%0b count=%0d ovf=%0b",
               name, event_valid, event_code, event_repeat, event_count, overflow,
               expValid, expCode, expRep, expCount, expOv);
    end
  endtask

  // Hold reset across two edges with idle inputs, then release away from the clock edge.
  task automatic doReset();
    reset_n        = 1'b0;
    keyboard       = 16'h0000;
    event_ready    = 1'b0;
    overflow_clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Single press with a ready consumer, then three keys in one cycle with a stalled consumer.
    vecs[0]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0};
    vecs[1]  = '{16'h0010, 1'b1, 1'b0, 1'b1, 4'd4,  3'd1, 1'b0};
    vecs[2]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0};
    vecs[3]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0};
    vecs[4]  = '{16'h8005, 1'b0, 1'b0, 1'b1, 4'd0,  3'd1, 1'b0};
    vecs[5]  = '{16'h8005, 1'b0, 1'b0, 1'b1, 4'd0,  3'd2, 1'b0};
    vecs[6]  = '{16'h8005, 1'b0, 1'b0, 1'b1, 4'd0,  3'd3, 1'b0};
    vecs[7]  = '{16'h8005, 1'b1, 1'b0, 1'b1, 4'd2,  3'd2, 1'b0};
    vecs[8]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd15, 3'd1, 1'b0};
    vecs[9]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0};
    // Keys 0..5 on separate cycles: fill to DEPTH, keys 4 and 5 wait in pending.
    vecs[10] = '{16'h0001, 1'b0, 1'b0, 1'b1, 4'd0,  3'd1, 1'b0};
    vecs[11] = '{16'h0003, 1'b0, 1'b0, 1'b1, 4'd0,  3'd2, 1'b0};
    vecs[12] = '{16'h0007, 1'b0, 1'b0, 1'b1, 4'd0,  3'd3, 1'b0};
    vecs[13] = '{16'h000F, 1'b0, 1'b0, 1'b1, 4'd0,  3'd4, 1'b0};
    vecs[14] = '{16'h001F, 1'b0, 1'b0, 1'b1, 4'd0,  3'd4, 1'b0};
    vecs[15] = '{16'h003F, 1'b0, 1'b0, 1'b1, 4'd0,  3'd4, 1'b0};
    // One pop lets key 4 in on the same edge; occupancy stays at DEPTH.
    vecs[16] = '{16'h003F, 1'b1, 1'b0, 1'b1, 4'd1,  3'd4, 1'b0};
    // Key 5 released while pending, then pressed again: that press is lost.
    vecs[17] = '{16'h001F, 1'b0, 1'b0, 1'b1, 4'd1,  3'd4, 1'b0};
    vecs[18] = '{16'h003F, 1'b0, 1'b0, 1'b1, 4'd1,  3'd4, 1'b1};
    vecs[19] = '{16'h003F, 1'b0, 1'b1, 1'b1, 4'd1,  3'd4, 1'b0};
    // Set and clear in the same cycle: set wins, then the flag stays sticky.
    vecs[20] = '{16'h001F, 1'b0, 1'b0, 1'b1, 4'd1,  3'd4, 1'b0};
    vecs[21] = '{16'h003F, 1'b0, 1'b1, 1'b1, 4'd1,  3'd4, 1'b1};
    vecs[22] = '{16'h003F, 1'b0, 1'b0, 1'b1, 4'd1,  3'd4, 1'b1};
    vecs[23] = '{16'h003F, 1'b0, 1'b1, 1'b1, 4'd1,  3'd4, 1'b0};
    // Drain: the still-pending key 5 enters on the first pop, then the queue empties in order.
    vecs[24] = '{16'h003F, 1'b1, 1'b0, 1'b1, 4'd2,  3'd4, 1'b0};
    vecs[25] = '{16'h003F, 1'b1, 1'b0, 1'b1, 4'd3,  3'd3, 1'b0};
    vecs[26] = '{16'h003F, 1'b1, 1'b0, 1'b1, 4'd4,  3'd2, 1'b0};
    vecs[27] = '{16'h003F, 1'b1, 1'b0, 1'b1, 4'd5,  3'd1, 1'b0};
    vecs[28] = '{16'h003F, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0};

    // Outputs must read idle while reset is held from time zero.
    reset_n        = 1'b0;
    keyboard       = 16'h0000;
    event_ready    = 1'b0;
    overflow_clear = 1'b0;
    #3;
    checkOutput("reset_idle", 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
    doReset();
    checkOutput("after_release", 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i].kb, vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCode, 1'b0,
                  vecs[i].expCount, vecs[i].expOv);
    end

    // Full FIFO with a pop and a new key 9 press on the same edge.
    doReset();
    applyStimulus(16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 1'b0);
    applyStimulus(16'h0007, 1'b0, 1'b0);
    applyStimulus(16'h000F, 1'b0, 1'b0);
    checkOutput("full_fill", 1'b1, 4'd0, 1'b0, 3'd4, 1'b0);
    applyStimulus(16'h020F, 1'b1, 1'b0);
    checkOutput("full_pop_push", 1'b1, 4'd1, 1'b0, 3'd4, 1'b0);
    applyStimulus(16'h020F, 1'b1, 1'b0);
    checkOutput("full_drain2", 1'b1, 4'd2, 1'b0, 3'd3, 1'b0);
    applyStimulus(16'h020F, 1'b1, 1'b0);
    checkOutput("full_drain3", 1'b1, 4'd3, 1'b0, 3'd2, 1'b0);
    applyStimulus(16'h020F, 1'b1, 1'b0);
    checkOutput("full_tail9", 1'b1, 4'd9, 1'b0, 3'd1, 1'b0);
    applyStimulus(16'h020F, 1'b1, 1'b0);
    checkOutput("full_empty", 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);

    // Three events queued plus overflow, then reset asserted between clock edges.
    doReset();
    applyStimulus(16'h000F, 1'b0, 1'b0);
    applyStimulus(16'h0007, 1'b0, 1'b0);
    applyStimulus(16'h000F, 1'b0, 1'b0);
    checkOutput("pre_reset", 1'b1, 4'd0, 1'b0, 3'd3, 1'b1);
    #2;
    reset_n  = 1'b0;
    keyboard = 16'h0000;
    #1;
    checkOutput("async_reset", 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("pending_discarded", 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);

    // A key already held when reset releases still produces a press.
    reset_n  = 1'b0;
    keyboard = 16'h0100;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("held_in_reset", 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(16'h0100, 1'b0, 1'b0);
    checkOutput("held_at_release", 1'b1, 4'd8, 1'b0, 3'd1, 1'b0);

    // Key 3 held for edges 0..17 with a ready consumer; repeats only when the feature is built in.
    doReset();
    for (int k = 0; k < 28; k++) begin
      logic expV;
      logic expR;
      expV = (k == 0) || (AutoRep && (k == 8 || k == 12 || k == 16));
      expR = expV && (k != 0);
      applyStimulus((k <= 17) ? 16'h0008 : 16'h0000, 1'b1, 1'b0);
      checkOutput($sformatf("repeat_edge%0d", k), expV, expV ? 4'd3 : 4'd0, expR,
                  expV ? 3'd1 : 3'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
